// File: rtl/acc_spi_responder.sv
// SPI mode-3 responder emulating an ADXL345-style register subset (DEVID, POWER_CTL, DATAX0..DATAZ1).
// SPI pins are oversampled on clk; the data registers are snapshotted at chip-select assertion.
module acc_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID       = 8'hE5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ncs,
  input  logic        scl,
  input  logic        sda,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [15:0] z_in,
  output logic        sdo,
  output logic [7:0]  power_ctl,
  output logic        measure,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] ncs_sync, scl_sync, sda_sync;
  logic ncs_s, scl_s, sda_s, ncs_prev, scl_prev;
  logic ncs_fall, scl_rise, scl_fall, byte_done;

  logic [6:0]  rx_sr;
  logic [7:0]  rx_byte, tx_sr, rd_data;
  logic [2:0]  bit_cnt;
  logic        rw, mb;
  logic [5:0]  addr, addr_step, rd_sel;
  logic [15:0] x_sh, y_sh, z_sh;

  // ncs chain resets low so a select held across reset release never looks like a fall
  always_ff @(posedge clk) begin
    if (reset) begin
      ncs_sync <= '0;
      scl_sync <= '1;
      sda_sync <= '0;
      ncs_prev <= 1'b0;
      scl_prev <= 1'b1;
    end else begin
      ncs_sync <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      ncs_prev <= ncs_s;
      scl_prev <= scl_s;
    end
  end

  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign ncs_fall  = ncs_prev & ~ncs_s;
  assign scl_rise  = ~scl_prev & scl_s & ~ncs_s;
  assign scl_fall  = scl_prev & ~scl_s & ~ncs_s;
  assign byte_done = scl_rise && (bit_cnt == 3'd7);

  assign rx_byte   = {rx_sr, sda_s};
  assign addr_step = mb ? addr + 6'd1 : addr;
  // Command byte looks up its own address; data bytes look up the stepped address
  assign rd_sel    = (state == CMD) ? rx_byte[5:0] : addr_step;

  always_comb begin
    rd_data = 8'h00;
    case (rd_sel)
      6'h00:   rd_data = DEVID;
      6'h2D:   rd_data = power_ctl;
      6'h32:   rd_data = x_sh[7:0];
      6'h33:   rd_data = x_sh[15:8];
      6'h34:   rd_data = y_sh[7:0];
      6'h35:   rd_data = y_sh[15:8];
      6'h36:   rd_data = z_sh[7:0];
      6'h37:   rd_data = z_sh[15:8];
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ncs_fall) state_nxt = CMD;
      CMD:     if (ncs_s) state_nxt = IDLE; else if (byte_done) state_nxt = DATA;
      DATA:    if (ncs_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sdo       <= 1'b0;
      power_ctl <= 8'h00;
      wr_strobe <= 1'b0;
      wr_addr   <= 6'h00;
      wr_data   <= 8'h00;
      rx_sr     <= '0;
      tx_sr     <= 8'h00;
      bit_cnt   <= 3'd0;
      rw        <= 1'b0;
      mb        <= 1'b0;
      addr      <= 6'h00;
      x_sh      <= 16'h0;
      y_sh      <= 16'h0;
      z_sh      <= 16'h0;
    end else begin
      wr_strobe <= 1'b0;
      if (state == IDLE) begin
        if (ncs_fall) begin
          x_sh    <= x_in;
          y_sh    <= y_in;
          z_sh    <= z_in;
          bit_cnt <= 3'd0;
          sdo     <= 1'b0;
        end
      end else if (ncs_s) begin
        sdo <= 1'b0;
      end else begin
        if (scl_rise) begin
          rx_sr   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          if (state == CMD) begin
            rw   <= rx_byte[7];
            mb   <= rx_byte[6];
            addr <= rx_byte[5:0];
            if (rx_byte[7]) tx_sr <= rd_data;
          end else begin
            if (!rw) begin
              wr_strobe <= 1'b1;
              wr_addr   <= addr;
              wr_data   <= rx_byte;
              if (addr == 6'h2D) power_ctl <= rx_byte;
            end else begin
              tx_sr <= rd_data;
            end
            addr <= addr_step;
          end
        end
        if (scl_fall && state == DATA && rw) begin
          sdo   <= tx_sr[7];
          tx_sr <= {tx_sr[6:0], 1'b0};
        end
      end
    end
  end

  assign measure = power_ctl[3];
  assign busy    = (state != IDLE);
endmodule

// File: tb/tb_acc_spi_responder.sv
// Bench for acc_spi_responder: directed vector table, corner-case sequences, randomized transactions.
module tb_acc_spi_responder;
  localparam int H = 6;

  logic clk = 1'b0, reset = 1'b1;
  logic ncs = 1'b1, scl = 1'b1, sda = 1'b0;
  logic [15:0] x_in = '0, y_in = '0, z_in = '0;
  logic sdo, measure, wr_strobe, busy;
  logic [7:0] power_ctl, wr_data;
  logic [5:0] wr_addr;

  acc_spi_responder #(.SYNC_STAGES(2), .DEVID(8'hE5)) dut (
    .clk(clk), .reset(reset), .ncs(ncs), .scl(scl), .sda(sda),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .sdo(sdo), .power_ctl(power_ctl),
    .measure(measure), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int strobe_cnt = 0, busy_lows = 0;
  logic [5:0] last_wa;
  logic [7:0] last_wd;
  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];
  logic [7:0] m_pc;

  always @(posedge clk) if (wr_strobe) begin
    strobe_cnt++;
    last_wa = wr_addr;
    last_wd = wr_data;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Mode-3 master: drive sda on scl fall, sample sdo just before scl rise; stop_bit cuts the frame short
  task automatic spi_txn(input int nbytes, input int stop_bit);
    int b;
    b = 0;
    busy_lows = 0;
    @(negedge clk) ncs = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbytes; i++) begin
      for (int k = 7; k >= 0; k--) begin
        if (b < stop_bit) begin
          scl = 1'b0; sda = tx_buf[i][k];
          repeat (H) @(negedge clk);
          rx_buf[i][k] = sdo;
          if (!busy) busy_lows++;
          scl = 1'b1;
          repeat (H) @(negedge clk);
          b++;
        end
      end
    end
    ncs = 1'b1; sda = 1'b0;
    repeat (2*H) @(negedge clk);
  endtask

  function automatic logic [7:0] mdl_rd(input logic [5:0] a, input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z, input logic [7:0] pc);
    logic [7:0] v;
    v = 8'h00;
    if (a == 6'h00) v = 8'hE5;
    else if (a == 6'h2D) v = pc;
    else if (a >= 6'h32 && a <= 6'h37) begin
      logic [47:0] all;
      all = {z, y, x};
      v = all[(a - 6'h32)*8 +: 8];
    end
    return v;
  endfunction

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    int          n;
    logic [15:0] x, y, z;
    logic [31:0] exp;
  } rvec_t;
  rvec_t tbl[7];

  initial begin
    tbl[0] = '{"t1_devid",   8'h80, 1, 16'h0000, 16'h0000, 16'h0000, 32'hE5000000};
    tbl[1] = '{"t3_mb_xy",   8'hF2, 4, 16'h1234, 16'hABCD, 16'h0000, 32'h3412CDAB};
    tbl[2] = '{"t4_nomb",    8'hB2, 2, 16'h1234, 16'h0000, 16'h0000, 32'h34340000};
    tbl[3] = '{"t6_wrap",    8'hFF, 2, 16'h0000, 16'h0000, 16'h0000, 32'h00E50000};
    tbl[4] = '{"pctl_rd",    8'hAD, 1, 16'h0000, 16'h0000, 16'h0000, 32'h08000000};
    tbl[5] = '{"z_rd",       8'hF6, 2, 16'h1111, 16'h2222, 16'hBEEF, 32'hEFBE0000};
    tbl[6] = '{"unmapped",   8'h81, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'h00000000};

    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_sdo", {31'b0, sdo}, 0);
    chk("rst_pctl", {24'b0, power_ctl}, 0);
    chk("rst_measure", {31'b0, measure}, 0);
    chk("rst_strobe", {31'b0, wr_strobe}, 0);
    chk("rst_waddr", {26'b0, wr_addr}, 0);
    chk("rst_wdata", {24'b0, wr_data}, 0);
    chk("rst_busy", {31'b0, busy}, 0);

    // T2: write POWER_CTL
    tx_buf[0] = 8'h2D; tx_buf[1] = 8'h08;
    spi_txn(2, 1000);
    m_pc = 8'h08;
    chk("t2_pctl", {24'b0, power_ctl}, 32'h08);
    chk("t2_measure", {31'b0, measure}, 1);
    chk("t2_strobes", strobe_cnt, 1);
    chk("t2_waddr", {26'b0, last_wa}, 32'h2D);
    chk("t2_wdata", {24'b0, last_wd}, 32'h08);

    foreach (tbl[r]) begin
      x_in = tbl[r].x; y_in = tbl[r].y; z_in = tbl[r].z;
      tx_buf[0] = tbl[r].cmd;
      for (int j = 1; j < 8; j++) tx_buf[j] = 8'h00;
      spi_txn(tbl[r].n + 1, 1000);
      for (int j = 0; j < tbl[r].n; j++)
        chk($sformatf("%s_b%0d", tbl[r].name, j), {24'b0, rx_buf[j+1]}, {24'b0, tbl[r].exp[31-8*j -: 8]});
      chk({tbl[r].name, "_busy_hi"}, busy_lows, 0);
      chk({tbl[r].name, "_busy_lo"}, {31'b0, busy}, 0);
    end

    // T4: x_in changes mid-read; snapshot must hold
    x_in = 16'h1234; tx_buf[0] = 8'hB2;
    fork
      spi_txn(3, 1000);
      begin repeat (H + 16*2*H) @(negedge clk); x_in = 16'h5678; end
    join
    chk("t4_snap_b0", {24'b0, rx_buf[1]}, 32'h34);
    chk("t4_snap_b1", {24'b0, rx_buf[2]}, 32'h34);

    // T5: aborted write after 5 data bits
    tx_buf[0] = 8'h2D; tx_buf[1] = 8'hFF;
    begin
      int sc;
      sc = strobe_cnt;
      spi_txn(2, 13);
      chk("t5_pctl", {24'b0, power_ctl}, {24'b0, m_pc});
      chk("t5_nostrobe", strobe_cnt, sc);
    end
    tx_buf[0] = 8'h80;
    spi_txn(2, 1000);
    chk("t5_next_txn", {24'b0, rx_buf[1]}, 32'hE5);

    // Randomized transactions against the register-map model
    for (int t = 0; t < 40; t++) begin
      logic rw, mb;
      logic [5:0] a;
      int n, exp_strobes;
      logic [15:0] rx_, ry_, rz_;
      rw = 1'($urandom_range(0, 1));
      mb = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: a = 6'h00;
        1: a = 6'h2D;
        2: a = 6'h3F;
        3: a = 6'h2C;
        4: a = 6'($urandom_range(6'h32, 6'h37));
        default: a = 6'($urandom);
      endcase
      n = $urandom_range(1, 4);
      rx_ = 16'($urandom); ry_ = 16'($urandom); rz_ = 16'($urandom);
      x_in = rx_; y_in = ry_; z_in = rz_;
      tx_buf[0] = {rw, mb, a};
      for (int j = 1; j <= n; j++) tx_buf[j] = 8'($urandom);
      exp_strobes = strobe_cnt + (rw ? 0 : n);
      spi_txn(n + 1, 1000);
      for (int j = 0; j < n; j++) begin
        if (rw) chk($sformatf("rnd%0d_rd%0d", t, j), {24'b0, rx_buf[j+1]}, {24'b0, mdl_rd(a, rx_, ry_, rz_, m_pc)});
        else if (a == 6'h2D) m_pc = tx_buf[j+1];
        if (!rw && j == n-1) begin
          chk($sformatf("rnd%0d_wa", t), {26'b0, last_wa}, {26'b0, a});
          chk($sformatf("rnd%0d_wd", t), {24'b0, last_wd}, {24'b0, tx_buf[j+1]});
        end
        a = a + {5'b0, mb};
      end
      chk($sformatf("rnd%0d_strobes", t), strobe_cnt, exp_strobes);
      chk($sformatf("rnd%0d_pctl", t), {24'b0, power_ctl}, {24'b0, m_pc});
      chk($sformatf("rnd%0d_measure", t), {31'b0, measure}, {31'b0, m_pc[3]});
    end

    // T6: reset mid-read with ncs held low across release
    tx_buf[0] = 8'h80;
    fork
      spi_txn(3, 1000);
      begin
        repeat (H + 16*H + 2*H + 3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_rst_sdo", {31'b0, sdo}, 0);
        chk("t6_rst_busy", {31'b0, busy}, 0);
        repeat (4*H) @(negedge clk);
        chk("t6_held_busy", {31'b0, busy}, 0);
        chk("t6_held_sdo", {31'b0, sdo}, 0);
      end
    join
    chk("t6_rst_pctl", {24'b0, power_ctl}, 0);
    chk("t6_rst_wdata", {24'b0, wr_data}, 0);
    tx_buf[0] = 8'h80;
    spi_txn(2, 1000);
    chk("t6_recover", {24'b0, rx_buf[1]}, 32'hE5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
